// File: rtl/tan_rr_scheduler.sv
// tan_rr_scheduler: round-robin front end that shares one tangent core
// among N_REQ requesters and aborts an operation after TIMEOUT wait cycles.
module tan_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_angle,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [2:0]                cur_id,
  output logic                      core_start,
  output logic [DATA_W-1:0]         core_angle,
  input  logic                      core_done,
  input  logic [DATA_W-1:0]         core_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TMAX  = 8'(TIMEOUT - 1);
  localparam logic [2:0] LAST0 = 3'(N_REQ - 1);

  state_t              r_state;
  logic [7:0]          r_timer;
  logic [2:0]          r_last;
  logic [N_REQ-1:0]    r_ack;
  logic [N_REQ-1:0]    r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic                r_busy;
  logic [2:0]          r_cur_id;
  logic                r_core_start;
  logic [DATA_W-1:0]   r_core_angle;

  logic                w_any;
  logic [2:0]          w_win;
  logic [DATA_W-1:0]   w_angle;
  logic [N_REQ-1:0]    w_win_oh;
  logic [N_REQ-1:0]    w_cur_oh;

  // Scan downward so the requester nearest after r_last is written last.
  always_comb begin
    w_any   = |req;
    w_win   = '0;
    w_angle = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(r_last) + i) % N_REQ]) begin
        w_win   = 3'((int'(r_last) + i) % N_REQ);
        w_angle = req_angle[((int'(r_last) + i) % N_REQ) * DATA_W +: DATA_W];
      end
    end
  end

  assign w_win_oh = N_REQ'(1) << w_win;
  assign w_cur_oh = N_REQ'(1) << r_cur_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_last       <= LAST0;
      r_ack        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_cur_id     <= '0;
      r_core_start <= 1'b0;
      r_core_angle <= '0;
    end else begin
      r_ack        <= '0;
      r_rsp_valid  <= '0;
      r_core_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cur_id     <= w_win;
            r_core_angle <= w_angle;
            r_ack        <= w_win_oh;
            r_core_start <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            r_rsp_data  <= core_result;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= w_cur_oh;
            r_state     <= S_RESP;
          end else if (r_timer == TMAX) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= w_cur_oh;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_RESP: begin
          r_last  <= r_cur_id;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack        = r_ack;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign busy       = r_busy;
  assign cur_id     = r_cur_id;
  assign core_start = r_core_start;
  assign core_angle = r_core_angle;

endmodule

// File: tb/tb_tan_rr_scheduler.sv
// tb_tan_rr_scheduler: scoreboard bench with a transaction-level
// round-robin model and a latency-programmable tangent core stand-in.
module tb_tan_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_angle;
  logic [N-1:0]    ack;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            busy;
  logic [2:0]      cur_id;
  logic            core_start;
  logic [DW-1:0]   core_angle;
  logic            core_done;
  logic [DW-1:0]   core_result;
  logic            m_done;
  logic            s_done;

  assign core_done = m_done | s_done;

  tan_rr_scheduler #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_angle(req_angle),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .cur_id(cur_id),
    .core_start(core_start), .core_angle(core_angle),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ang; int lat; } job_t;
  typedef struct { int id; logic [31:0] ang; } g_t;
  typedef struct { int id; logic [31:0] data; logic err; int dly; } r_t;

  job_t jobs[N][$];
  g_t   exp_g[$];
  r_t   exp_r[$];
  int   lat_q[$];
  int   last_m;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ack_cyc = 0;
  bit   chk_busy_low = 0;

  function automatic logic [31:0] ref_tan(input logic [31:0] a);
    if (a == 32'h3F80_0000) return 32'h3FC7_5923;
    return a * 32'd3 + 32'h0123_4567;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops expectations whenever the DUT presents ack or rsp_valid.
  always @(negedge clk) begin
    g_t g;
    r_t r;
    if (chk_busy_low) begin
      check("busy_after_resp", 32'(busy), 32'd0);
      chk_busy_low = 0;
    end
    if (ack != 0 || core_start) begin
      check("start_with_ack", 32'(core_start), 32'd1);
      check("ack_onehot", 32'($onehot(ack)), 32'd1);
      check("busy_at_issue", 32'(busy), 32'd1);
      if (exp_g.size() == 0) fail_now("unexpected_ack");
      else begin
        g = exp_g.pop_front();
        check("grant_id", 32'(ack), 32'(1 << g.id));
        check("cur_id_issue", 32'(cur_id), 32'(g.id));
        check("core_angle", core_angle, g.ang);
      end
      ack_cyc = cyc;
    end
    if (rsp_valid != 0) begin
      if (exp_r.size() == 0) fail_now("unexpected_rsp");
      else begin
        r = exp_r.pop_front();
        check("rsp_id", 32'(rsp_valid), 32'(1 << r.id));
        check("cur_id_resp", 32'(cur_id), 32'(r.id));
        check("rsp_data", rsp_data, r.data);
        check("rsp_err", 32'(rsp_err), 32'(r.err));
        check("rsp_delay", 32'(cyc - ack_cyc), 32'(r.dly));
      end
      chk_busy_low = 1;
    end
  end

  // Core stand-in: done after a per-operation latency, 0 = never.
  initial begin
    int lat;
    m_done = 1'b0;
    core_result = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (core_start && rst_n) begin
        lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
        if (lat > 0) begin
          logic [31:0] a;
          a = core_angle;
          repeat (lat) @(posedge clk);
          #1;
          m_done = 1'b1;
          core_result = ref_tan(a);
          @(posedge clk);
          #1;
          m_done = 1'b0;
          core_result = $urandom;
        end
      end
    end
  end

  task automatic add_job(input int k, input logic [31:0] a, input int lat);
    job_t j;
    j.ang = a;
    j.lat = lat;
    jobs[k].push_back(j);
  endtask

  // Model: each arbitration picks the first requester with work left
  // after the previous winner; requesters re-present promptly after ack.
  task automatic run_round();
    int ptr[N];
    int left;
    int k;
    int n;
    job_t j;
    g_t g;
    r_t r;
    left = 0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      ptr[i] = 0;
      left += jobs[i].size();
    end
    while (left > 0) begin
      for (int i = 1; i <= N; i++) begin
        k = (last_m + i) % N;
        if (ptr[k] < jobs[k].size()) break;
      end
      j = jobs[k][ptr[k]];
      ptr[k]++;
      left--;
      g.id = k;
      g.ang = j.ang;
      exp_g.push_back(g);
      lat_q.push_back(j.lat);
      r.id = k;
      r.data = (j.lat > 0) ? ref_tan(j.ang) : 32'd0;
      r.err = (j.lat == 0);
      r.dly = (j.lat > 0) ? j.lat + 1 : TO + 1;
      exp_r.push_back(r);
      last_m = k;
    end
    for (int i = 0; i < N; i++) begin
      if (jobs[i].size() != 0) begin
        req[i] = 1'b1;
        req_angle[i*DW +: DW] = jobs[i][0].ang;
      end
    end
    n = 0;
    while ((req != 0 || exp_r.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          void'(jobs[i].pop_front());
          if (jobs[i].size() != 0) req_angle[i*DW +: DW] = jobs[i][0].ang;
          else begin
            req[i] = 1'b0;
            req_angle[i*DW +: DW] = $urandom;
          end
        end
      end
    end
    if (n >= 3000) begin
      fail_now("round_timeout");
      for (int i = 0; i < N; i++) jobs[i].delete();
      exp_g.delete();
      exp_r.delete();
      lat_q.delete();
      req = '0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int pick_lat();
    int v;
    v = $urandom_range(0, 9);
    if (v == 0) return 0;
    if (v == 1) return TO;
    return $urandom_range(1, 8);
  endfunction

  initial begin
    g_t g;
    int n;
    rst_n = 1'b0;
    req = '0;
    req_angle = '0;
    s_done = 1'b0;
    last_m = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cur_id", 32'(cur_id), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_core_angle", core_angle, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) add_job(i, 32'h4000_0000 + 32'(i), 2 + i);
    run_round();

    add_job(0, 32'h3F80_0000, 5);
    run_round();

    for (int i = 0; i < 4; i++) add_job(0, $urandom, $urandom_range(1, 4));
    for (int i = 0; i < 3; i++) add_job(2, $urandom, $urandom_range(1, 4));
    run_round();

    add_job(1, 32'h1111_0000, 0);
    add_job(1, 32'h2222_0000, 3);
    run_round();

    add_job(3, 32'h3333_0000, TO);
    run_round();

    for (int rd = 0; rd < 8; rd++) begin
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 2);
        for (int m = 0; m < n; m++) add_job(i, $urandom, pick_lat());
      end
      run_round();
    end

    // Abort an operation in WAIT, then present a stale done.
    g.id = 0;
    g.ang = 32'h5555_AAAA;
    exp_g.push_back(g);
    lat_q.push_back(0);
    req[0] = 1'b1;
    req_angle[DW-1:0] = g.ang;
    n = 0;
    while (ack[0] !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) fail_now("abort_ack_timeout");
    req[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_err", 32'(rsp_err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_core_angle", core_angle, 32'd0);
    @(posedge clk);
    #1;
    s_done = 1'b1;
    @(posedge clk);
    #1;
    s_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stale_no_rsp", 32'(rsp_valid), 32'd0);
      check("stale_idle", 32'(busy), 32'd0);
    end
    last_m = N - 1;
    add_job(0, 32'h3F80_0000, 2);
    run_round();

    if (exp_g.size() != 0 || exp_r.size() != 0) fail_now("leftover_expect");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tan_rr_scheduler.md
Name: tan_rr_scheduler

Overview:
Round-robin scheduler that shares one tangent core (start/done handshake, 32-bit angle in, 32-bit result out) among N_REQ requesters. It arbitrates pending requests and latches the winner's angle. It then issues a one-cycle start pulse, waits for done or a timeout, and returns the result to the granted requester. It sits between the application-side trig users and the single tangent datapath/controller pair.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 32, angle/result width
TIMEOUT, 255, maximum WAIT cycles before the operation is aborted with an error (1..255)

Ports:
clk  in  1  clock; all logic is rising-edge
rst_n  in  1  synchronous active-low reset
req  in  N_REQ  request level per requester; must be held until its ack
req_angle  in  N_REQ*DATA_W  packed angles; requester k uses bits [k*DATA_W +: DATA_W]
ack  out  N_REQ  one-cycle pulse; the operand of requester k has been accepted
rsp_valid  out  N_REQ  one-cycle pulse; the response for requester k is on rsp_data/rsp_err
rsp_data  out  DATA_W  result; valid only while rsp_valid is nonzero
rsp_err  out  1  timeout flag; qualified by rsp_valid
busy  out  1  high in every state except IDLE
cur_id  out  3  index of the granted requester; held from ISSUE through RESP
core_start  out  1  one-cycle start pulse to the tangent core
core_angle  out  DATA_W  latched angle; stable from ISSUE until the next grant
core_done  in  1  core completion strobe
core_result  in  DATA_W  core result; sampled when core_done is high in WAIT

Behaviour:
- Reset (rst_n low at the edge):
  - State goes to IDLE. ack, rsp_valid, rsp_data, rsp_err, busy, cur_id, core_start, core_angle and the timer are all 0.
  - last_grant is set to N_REQ-1, so requester 0 has first priority.
  - Reset mid-operation abandons the transaction. No rsp_valid is produced for it. The core is not aborted; a stale core_done seen in IDLE or ISSUE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req is nonzero, the winner is the first set bit searching upward from last_grant+1, wrapping modulo N_REQ.
  - On that edge, latch cur_id and core_angle, then go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - ack[cur_id]=1 and core_start=1. Clear the timer, then go to WAIT.
  - core_done in this cycle is ignored.
- WAIT:
  - If core_done is high: latch rsp_data=core_result and rsp_err=0, then go to RESP.
  - Else, if timer==TIMEOUT-1: set rsp_data=0 and rsp_err=1, then go to RESP.
  - Otherwise, increment the timer.
  - WAIT therefore lasts at most TIMEOUT cycles.
  - If core_done arrives on the timeout cycle, done wins and rsp_err=0.
- RESP (exactly 1 cycle):
  - rsp_valid[cur_id]=1. Set last_grant=cur_id, then go to IDLE.
  - The registered rsp_data/rsp_err are held until the next RESP. Consumers use them only with rsp_valid.
- Latency: req sampled in IDLE at cycle t gives ack/core_start at t+1. If core_done is at cycle t+1+L (L≥1), rsp_valid is at t+2+L.
- Throughput: the next arbitration happens in the IDLE cycle after RESP. The minimum gap is 4 cycles per operation with L=1.
- Request rules:
  - A requester drops req after its ack; the next arbitration is at least 3 cycles later.
  - If req is still high at the next IDLE, it is treated as a new request.
  - If req is dropped before being granted, no operation occurs.
- ack, rsp_valid and core_start are never asserted for more than one bit or one cycle at a time.
- A changing req_angle after ack does not affect core_angle.

Test Plan:
1. Single request: after reset, req=0001, angle 0x3F800000; core model returns 0x3FC75923 with L=5.
   - Required: ack[0] and core_start at t+1, core_angle=0x3F800000, rsp_valid[0] at t+7 with data 0x3FC75923 and err=0, busy low at t+8.
2. Simultaneous requests: req=1111 right after reset, each requester dropping req after its ack.
   - Required: grants in order 0,1,2,3, each with the correct angle forwarded and rsp_valid routed to the matching index.
3. Fairness: req0 held continuously plus req2 pending.
   - Required: grant sequence alternates 0,2,0,2; req0 is never granted twice in a row while req2 waits.
4. Timeout: TIMEOUT=16 and the core never asserts done.
   - Required: rsp_valid with err=1 and rsp_data=0 exactly 16 WAIT cycles after ISSUE. A following request then completes normally with err=0.
5. Done/timeout collision: core_done asserted in the cycle where timer==TIMEOUT-1.
   - Required: rsp_err=0 and rsp_data=core_result.
6. Reset during WAIT: drop rst_n for one edge, then the core asserts a stale core_done.
   - Required: all outputs 0 after the reset edge, no rsp_valid for the aborted request. A new req=0001 gets a fresh core_start and a correct response.
